// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl
//   Bus master sitting between the CPU memory stage and the peripheral slaves.
//   It turns a stall-based CPU request into a registered select/we/addr/data
//   transaction, waits for the selected slave's ack, and returns the read data.
//   Only one transaction is outstanding at a time.
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   -> a BUSY-cycle counter aborts a transaction to a stuck slave
//                  after TIMEOUT BUSY cycles (err pulse)
//     undefined -> no counter; BUSY waits for ack indefinitely
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cpu_ce_i/we_i       CPU request valid / write enable
//   cpu_addr_i/data_i   CPU byte address / write data
//   cpu_data_o          read data, valid in the DONE cycle (0 in ERR)
//   cpu_stall_o         holds the CPU pipeline while a request is in flight
//   cpu_err_o           one-cycle pulse on decode error or timeout
//   bus_addr_o/data_o   registered address / write data to the slaves
//   bus_we_o            registered write enable
//   bus_select_o        one-hot slave select
//   bus_data_i          slave read data, slave k on [32k+31:32k]
//   bus_ack_i           per-slave ack (may be combinational from select)
module periph_bus_ctrl #(
  parameter int NSLV      = 4,
  parameter int SLV_SHIFT = 28,
  parameter int SLV_BITS  = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_ce_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 cpu_err_o,
  output logic [31:0]          bus_addr_o,
  output logic [31:0]          bus_data_o,
  output logic                 bus_we_o,
  output logic [NSLV-1:0]      bus_select_o,
  input  logic [32*NSLV-1:0]   bus_data_i,
  input  logic [NSLV-1:0]      bus_ack_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // Elaboration-time guard against inconsistent parameter sets.
  if (NSLV > (2 ** SLV_BITS) || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("periph_bus_ctrl: inconsistent NSLV/SLV_BITS or TIMEOUT/CNT_W");
  end

  logic [1:0]          state;
  logic [SLV_BITS-1:0] req_idx;
  logic                req_ok;
  logic [NSLV-1:0]     req_onehot;
  logic                ack_hit;
  logic [31:0]         rd_data;
  logic [31:0]         rd_terms [NSLV];
  logic                timeout;

  assign req_idx = cpu_addr_i[SLV_SHIFT +: SLV_BITS];
  assign req_ok  = (32'(req_idx) < 32'(NSLV));

  // Only the selected slave's ack counts; select is zero outside BUSY, so acks
  // arriving in IDLE/DONE/ERR are ignored as well.
  assign ack_hit = |(bus_ack_i & bus_select_o);

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
    assign req_onehot[gi] = (req_idx == SLV_BITS'(gi));
    assign rd_terms[gi]   = bus_select_o[gi] ? bus_data_i[32*gi +: 32] : 32'h0;
  end

  // AND-OR read mux keyed by the registered one-hot select.
  always_comb begin
    rd_data = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      rd_data = rd_data | rd_terms[i];
    end
  end

  assign cpu_stall_o = ((state == IDLE) && cpu_ce_i) || (state == BUSY);
  assign cpu_err_o   = (state == ERR);

`ifdef BUS_TIMEOUT_EN
  // cnt holds the 1-based index of the current BUSY cycle, so the timeout
  // fires during BUSY cycle TIMEOUT and BUSY lasts exactly TIMEOUT cycles.
  logic [CNT_W-1:0] cnt;

  assign timeout = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && cpu_ce_i && req_ok) begin
      cnt <= CNT_W'(1);
    end else if (state == BUSY && !ack_hit && !timeout) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus_addr_o   <= 32'h0;
      bus_data_o   <= 32'h0;
      bus_we_o     <= 1'b0;
      bus_select_o <= '0;
      cpu_data_o   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_ce_i) begin
            bus_addr_o <= cpu_addr_i;
            bus_data_o <= cpu_data_i;
            if (req_ok) begin
              bus_we_o     <= cpu_we_i;
              bus_select_o <= req_onehot;
              state        <= BUSY;
            end else begin
              // Decode error: no select, no write strobe.
              cpu_data_o <= 32'h0;
              state      <= ERR;
            end
          end
        end
        BUSY: begin
          // Ack takes priority over a timeout in the same cycle.
          if (ack_hit) begin
            if (!bus_we_o) begin
              cpu_data_o <= rd_data;
            end
            bus_select_o <= '0;
            bus_we_o     <= 1'b0;
            state        <= DONE;
          end else if (timeout) begin
            bus_select_o <= '0;
            bus_we_o     <= 1'b0;
            cpu_data_o   <= 32'h0;
            state        <= ERR;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
